prog_loader_framed: RTL and testbench

- Parametrised successor to the simple serial program loader.
- Receives framed, checksummed records over a UART RX line and writes the payload bytes into external memory through an address/data/write-strobe port.
- Sits beside the CPU and drives the external 21-bit bus while the system is held in programming mode.
- Adds over its predecessor: configurable address width, bit rate and write-strobe length; explicit frame sync and length; checksum; inter-byte timeout; status outputs.

---
 rtl/prog_loader_framed_pkg.sv | 27 ++
 rtl/prog_loader_framed_uart_rx_byte.sv | 98 +++++++++
 rtl/prog_loader_framed.sv | 178 +++++++++++++++++
 tb/tb_prog_loader_framed.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_framed_pkg.sv
// Shared types and constants for the framed program loader.
// Covers the frame FSM, the byte receiver FSM and the frame field sizes.
package prog_loader_framed_pkg;

    typedef enum logic [3:0] {
        HUNT,
        ADR2,
        ADR1,
        ADR0,
        LENH,
        LENL,
        DATA,
        WRITE,
        CHK
    } frame_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE       = 8'h55;
    localparam int         ADR_FIELD_BYTES = 3;

endpackage

// File: rtl/prog_loader_framed_uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-FF input synchroniser and a start-bit glitch filter.
// Delivers a one-cycle valid pulse with the byte, or a one-cycle ferr pulse on a bad stop bit.
module uart_rx_byte
    import prog_loader_framed_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       valid,
    output logic       ferr
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        r_state;
    rx_state_t        w_next;
    logic [1:0]       r_sync;
    logic             r_rx_d;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_valid;
    logic             r_ferr;
    logic             w_rx;
    logic             w_half;
    logic             w_full;

    assign w_rx    = r_sync[1];
    assign w_half  = (r_cnt == CNT_HALF);
    assign w_full  = (r_cnt == CNT_FULL);
    assign rx_byte = r_shift;
    assign valid   = r_valid;
    assign ferr    = r_ferr;

    // Synchroniser flops reset to the idle level so reset release never looks like a start edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b11;
            r_rx_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], rx};
            r_rx_d <= w_rx;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:  if (r_rx_d && !w_rx)             w_next = RX_START;
            RX_START: if (w_half)                      w_next = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_full && (r_bit == 3'd7))   w_next = RX_STOP;
            RX_STOP:  if (w_full)                      w_next = RX_IDLE;
            default:                                   w_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            if ((r_state == RX_IDLE) || (r_state != w_next) || w_full) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if ((r_state == RX_DATA) && w_full) begin
                r_shift <= {w_rx, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end else if (r_state != RX_DATA) begin
                r_bit <= '0;
            end

            r_valid <= (r_state == RX_STOP) && w_full && w_rx;
            r_ferr  <= (r_state == RX_STOP) && w_full && !w_rx;
        end
    end

endmodule

// File: rtl/prog_loader_framed.sv
// Framed, checksummed program loader: receives 55/A2/A1/A0/LH/LL/payload/C records over UART
// and writes each payload byte to external memory with a WRITE_CYCLES-long strobe.
module prog_loader_framed
    import prog_loader_framed_pkg::*;
#(
    parameter int ADR_WIDTH    = 21,
    parameter int CLKS_PER_BIT = 104,
    parameter int WRITE_CYCLES = 4,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [ADR_WIDTH-1:0] adr,
    output logic [7:0]           data,
    output logic                 write,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int               TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int               TMR_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST       = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam int               WCNT_W         = $clog2(WRITE_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST     = WCNT_W'(WRITE_CYCLES);

    generate
        if ((ADR_WIDTH < 1) || (ADR_WIDTH > ADR_FIELD_BYTES * 8) || (CLKS_PER_BIT < 8) ||
            (WRITE_CYCLES < 1) || (WRITE_CYCLES > 8) || (WRITE_CYCLES >= 9 * CLKS_PER_BIT) ||
            (TIMEOUT_BITS < 1)) begin : g_bad_params
            $error("prog_loader_framed: parameter out of range");
        end
    endgenerate

    frame_state_t         r_state;
    frame_state_t         w_next;
    logic [ADR_WIDTH-1:0] r_adr;
    logic [7:0]           r_data;
    logic [15:0]          r_len;
    logic [7:0]           r_sum;
    logic [WCNT_W-1:0]    r_wcnt;
    logic [TMR_W-1:0]     r_timer;
    logic                 r_done;
    logic                 r_err;
    logic [7:0]           w_byte;
    logic                 w_valid;
    logic                 w_ferr;
    logic                 w_done_set;
    logic                 w_err_set;
    logic                 w_write_end;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk    (clk),
        .reset  (reset),
        .rx     (rx),
        .rx_byte(w_byte),
        .valid  (w_valid),
        .ferr   (w_ferr)
    );

    // The strobe is decoded from registered state so an async reset drops it immediately.
    assign write       = (r_state == WRITE) && (r_wcnt != WCNT_LAST);
    assign w_write_end = (r_state == WRITE) && (r_wcnt == WCNT_LAST);
    assign adr         = r_adr;
    assign data        = r_data;
    assign busy        = (r_state != HUNT);
    assign done        = r_done;
    assign err         = r_err;

    always_comb begin
        w_next     = r_state;
        w_done_set = 1'b0;
        w_err_set  = 1'b0;
        case (r_state)
            HUNT:  if (w_valid && (w_byte == SYNC_BYTE)) w_next = ADR2;
            ADR2:  if (w_valid) w_next = ADR1;
            ADR1:  if (w_valid) w_next = ADR0;
            ADR0:  if (w_valid) w_next = LENH;
            LENH:  if (w_valid) w_next = LENL;
            LENL:  if (w_valid) w_next = ({r_len[15:8], w_byte} == 16'd0) ? CHK : DATA;
            DATA:  if (w_valid) w_next = WRITE;
            WRITE: if (w_write_end) w_next = (r_len == 16'd1) ? CHK : DATA;
            CHK: begin
                if (w_valid) begin
                    w_next = HUNT;
                    if (8'(r_sum + w_byte) == 8'd0) begin
                        w_done_set = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            default: w_next = HUNT;
        endcase

        // Abort on a broken byte or a stalled line; ferr and valid are never coincident.
        if ((r_state != HUNT) && (r_state != WRITE) &&
            (w_ferr || ((r_timer == TMR_LAST) && !w_valid))) begin
            w_next     = HUNT;
            w_err_set  = 1'b1;
            w_done_set = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_adr   <= '0;
            r_data  <= '0;
            r_len   <= '0;
            r_sum   <= '0;
            r_wcnt  <= '0;
            r_timer <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= w_done_set;

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if ((r_state == HUNT) && (w_next == ADR2)) begin
                r_err <= 1'b0;
            end

            if ((r_state == HUNT) || w_valid) begin
                r_timer <= '0;
            end else if (r_timer != TMR_LAST) begin
                r_timer <= r_timer + TMR_W'(1);
            end

            if ((r_state == WRITE) && (r_wcnt != WCNT_LAST)) begin
                r_wcnt <= r_wcnt + WCNT_W'(1);
            end else begin
                r_wcnt <= '0;
            end

            if (w_valid) begin
                case (r_state)
                    HUNT: r_sum <= '0;
                    ADR2, ADR1, ADR0: begin
                        // Shifting 24 address bits through an ADR_WIDTH register keeps only the low bits.
                        r_adr <= ADR_WIDTH'({r_adr, w_byte});
                        r_sum <= r_sum + w_byte;
                    end
                    LENH: begin
                        r_len[15:8] <= w_byte;
                        r_sum       <= r_sum + w_byte;
                    end
                    LENL: begin
                        r_len[7:0] <= w_byte;
                        r_sum      <= r_sum + w_byte;
                    end
                    DATA: begin
                        r_data <= w_byte;
                        r_sum  <= r_sum + w_byte;
                    end
                    default: ;
                endcase
            end

            if (w_write_end) begin
                r_adr <= r_adr + ADR_WIDTH'(1);
                r_len <= r_len - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader_framed.sv
// Directed bench for prog_loader_framed: serialises hand-built frames onto rx and
// checks write pulses, done/err/busy behaviour against hand-computed expectations.
module tb_prog_loader_framed;

    localparam int AW  = 21;
    localparam int CPB = 16;
    localparam int WC  = 4;
    localparam int TOB = 64;

    typedef logic [7:0] byte_q_t[$];

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          rx    = 1'b1;
    logic [AW-1:0] adr;
    logic [7:0]    data;
    logic          write;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    prog_loader_framed #(
        .ADR_WIDTH   (AW),
        .CLKS_PER_BIT(CPB),
        .WRITE_CYCLES(WC),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .adr  (adr),
        .data (data),
        .write(write),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] wr_adr_q[$];
    logic [7:0]    wr_data_q[$];
    int            wr_len_q[$];
    int            done_cnt     = 0;
    int            both_cnt     = 0;
    int            unstable_cnt = 0;
    int            cur_len      = 0;
    logic          wr_prev      = 1'b0;
    logic [AW-1:0] hold_adr;
    logic [7:0]    hold_data;

    // Passive monitor: records each write pulse, its length and any adr/data movement during it.
    always @(negedge clk) begin
        if (write && !wr_prev) begin
            wr_adr_q.push_back(adr);
            wr_data_q.push_back(data);
            hold_adr  = adr;
            hold_data = data;
            cur_len   = 1;
        end else if (write) begin
            cur_len++;
            if ((adr != hold_adr) || (data != hold_data)) unstable_cnt++;
        end
        if (!write && wr_prev) wr_len_q.push_back(cur_len);
        wr_prev = write;
        if (done) done_cnt++;
        if (done && err) both_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wr_adr_q.delete();
        wr_data_q.delete();
        wr_len_q.delete();
        done_cnt = 0;
    endtask

    task automatic drive_bits(input logic [7:0] b);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        drive_bits(b);
        rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input byte_q_t q);
        foreach (q[i]) send_byte(q[i], 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (adr !== '0)     begin n_fail++; $display("FAIL reset_adr: got %h, expected 0", adr); end
        n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", data); end
        n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b, expected 0", write); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done); end
        n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        byte_q_t       f;
        logic [AW-1:0] exp_adr[3]  = '{21'h000100, 21'h000101, 21'h000102};
        logic [7:0]    exp_data[3] = '{8'hAA, 8'hBB, 8'hCC};
        clear_mon();
        f = '{8'h55, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hCB};
        send_frame(f);
        n_checks++; if (wr_adr_q.size() != 3) begin n_fail++; $display("FAIL basic_nwrites: got %0d, expected 3", wr_adr_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < wr_adr_q.size()) begin
                n_checks++; if (wr_adr_q[i] !== exp_adr[i])   begin n_fail++; $display("FAIL basic_adr%0d: got %h, expected %h", i, wr_adr_q[i], exp_adr[i]); end
                n_checks++; if (wr_data_q[i] !== exp_data[i]) begin n_fail++; $display("FAIL basic_data%0d: got %h, expected %h", i, wr_data_q[i], exp_data[i]); end
            end
            if (i < wr_len_q.size()) begin
                n_checks++; if (wr_len_q[i] != WC) begin n_fail++; $display("FAIL basic_wlen%0d: got %0d, expected %0d", i, wr_len_q[i], WC); end
            end
        end
        n_checks++; if (done_cnt != 1)       begin n_fail++; $display("FAIL basic_done: got %0d pulses, expected 1", done_cnt); end
        n_checks++; if (err !== 1'b0)        begin n_fail++; $display("FAIL basic_err: got %b, expected 0", err); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL basic_busy: got %b, expected 0", busy); end
        n_checks++; if (adr !== 21'h000103)  begin n_fail++; $display("FAIL basic_adr_after: got %h, expected 000103", adr); end
    endtask

    task automatic test_bad_checksum();
        byte_q_t f;
        clear_mon();
        f = '{8'h55, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hCC};
        send_frame(f);
        n_checks++; if (wr_adr_q.size() != 3) begin n_fail++; $display("FAIL badchk_nwrites: got %0d, expected 3", wr_adr_q.size()); end
        n_checks++; if (done_cnt != 0)  begin n_fail++; $display("FAIL badchk_done: got %0d pulses, expected 0", done_cnt); end
        n_checks++; if (err !== 1'b1)   begin n_fail++; $display("FAIL badchk_err: got %b, expected 1", err); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL badchk_busy: got %b, expected 0", busy); end
        send_byte(8'h12, 1'b0);
        n_checks++; if (err !== 1'b1)   begin n_fail++; $display("FAIL badchk_err_sticky: got %b, expected 1", err); end
        send_byte(8'h55, 1'b0);
        n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL badchk_err_clear: got %b, expected 0", err); end
        n_checks++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL badchk_busy_sync: got %b, expected 1", busy); end
        f = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'hF0};
        send_frame(f);
        n_checks++; if (done_cnt != 1)  begin n_fail++; $display("FAIL badchk_next_done: got %0d pulses, expected 1", done_cnt); end
    endtask

    task automatic test_wrap();
        byte_q_t       f;
        logic [AW-1:0] exp_adr[2]  = '{21'h1FFFFF, 21'h000000};
        logic [7:0]    exp_data[2] = '{8'h11, 8'h22};
        clear_mon();
        f = '{8'h55, 8'h1F, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'hAE};
        send_frame(f);
        n_checks++; if (wr_adr_q.size() != 2) begin n_fail++; $display("FAIL wrap_nwrites: got %0d, expected 2", wr_adr_q.size()); end
        for (int i = 0; i < 2; i++) begin
            if (i < wr_adr_q.size()) begin
                n_checks++; if (wr_adr_q[i] !== exp_adr[i])   begin n_fail++; $display("FAIL wrap_adr%0d: got %h, expected %h", i, wr_adr_q[i], exp_adr[i]); end
                n_checks++; if (wr_data_q[i] !== exp_data[i]) begin n_fail++; $display("FAIL wrap_data%0d: got %h, expected %h", i, wr_data_q[i], exp_data[i]); end
            end
        end
        n_checks++; if (done_cnt != 1)      begin n_fail++; $display("FAIL wrap_done: got %0d pulses, expected 1", done_cnt); end
        n_checks++; if (adr !== 21'h000001) begin n_fail++; $display("FAIL wrap_adr_after: got %h, expected 000001", adr); end
    endtask

    task automatic test_garbage_then_empty();
        byte_q_t f;
        clear_mon();
        f = '{8'h00, 8'hFF, 8'h12};
        foreach (f[i]) begin
            send_byte(f[i], 1'b0);
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL garbage_busy%0d: got %b, expected 0", i, busy); end
        end
        f = '{8'h55, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'hF0};
        send_frame(f);
        n_checks++; if (wr_adr_q.size() != 0) begin n_fail++; $display("FAIL empty_nwrites: got %0d, expected 0", wr_adr_q.size()); end
        n_checks++; if (done_cnt != 1)  begin n_fail++; $display("FAIL empty_done: got %0d pulses, expected 1", done_cnt); end
        n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL empty_err: got %b, expected 0", err); end
    endtask

    task automatic test_timeout();
        byte_q_t f;
        clear_mon();
        f = '{8'h55, 8'h00, 8'h01, 8'h00, 8'h00};
        send_frame(f);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_busy_start: got %b, expected 1", busy); end
        repeat (900) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early: busy got %b, expected 1", busy); end
        n_checks++; if (err !== 1'b0)  begin n_fail++; $display("FAIL tmo_early_err: got %b, expected 0", err); end
        repeat (200) @(negedge clk);
        n_checks++; if (err !== 1'b1)  begin n_fail++; $display("FAIL tmo_err: got %b, expected 1", err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b, expected 0", busy); end
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL tmo_done: got %0d pulses, expected 0", done_cnt); end
        f = '{8'h55, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hCB};
        send_frame(f);
        n_checks++; if (done_cnt != 1)         begin n_fail++; $display("FAIL tmo_next_done: got %0d pulses, expected 1", done_cnt); end
        n_checks++; if (err !== 1'b0)          begin n_fail++; $display("FAIL tmo_next_err: got %b, expected 0", err); end
        n_checks++; if (wr_adr_q.size() != 3)  begin n_fail++; $display("FAIL tmo_next_nwrites: got %0d, expected 3", wr_adr_q.size()); end
    endtask

    task automatic test_frame_error();
        byte_q_t f;
        clear_mon();
        f = '{8'h55, 8'h00, 8'h02, 8'h00, 8'h00, 8'h02, 8'h33};
        send_frame(f);
        send_byte(8'h44, 1'b1);
        n_checks++; if (wr_adr_q.size() != 1) begin n_fail++; $display("FAIL ferr_nwrites: got %0d, expected 1", wr_adr_q.size()); end
        if (wr_adr_q.size() > 0) begin
            n_checks++; if (wr_adr_q[0] !== 21'h000200) begin n_fail++; $display("FAIL ferr_adr: got %h, expected 000200", wr_adr_q[0]); end
            n_checks++; if (wr_data_q[0] !== 8'h33)     begin n_fail++; $display("FAIL ferr_data: got %h, expected 33", wr_data_q[0]); end
        end
        n_checks++; if (err !== 1'b1)  begin n_fail++; $display("FAIL ferr_err: got %b, expected 1", err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy: got %b, expected 0", busy); end
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL ferr_done: got %0d pulses, expected 0", done_cnt); end
    endtask

    task automatic test_reset_in_write();
        byte_q_t f;
        logic    seen;
        clear_mon();
        f = '{8'h55, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01};
        send_frame(f);
        drive_bits(8'h77);
        rx   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3 * CPB && !seen; i++) begin
            @(negedge clk);
            if (write) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstw_seen: write got %b within bound, expected 1", seen); end
        if (seen) begin
            #2 reset = 1'b1;
            #1;
            n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL rstw_write: got %b, expected 0", write); end
            n_checks++; if (adr !== '0)     begin n_fail++; $display("FAIL rstw_adr: got %h, expected 0", adr); end
            n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL rstw_busy: got %b, expected 0", busy); end
            n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL rstw_data: got %h, expected 0", data); end
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_wrap();
        test_garbage_then_empty();
        test_timeout();
        test_frame_error();
        test_reset_in_write();
        n_checks++; if (both_cnt != 0)     begin n_fail++; $display("FAIL done_err_overlap: got %0d cycles, expected 0", both_cnt); end
        n_checks++; if (unstable_cnt != 0) begin n_fail++; $display("FAIL write_stability: got %0d changes, expected 0", unstable_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
